dlfloat_mac_host: RTL and testbench

DLFLOAT_MAC_HOST -- requirements
Module: dlfloat_mac_host

---
 rtl/dlfloat_mac_host.sv | 111 +++++++++++
 tb/tb_dlfloat_mac_host.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dlfloat_mac_host.sv
// Host-side sequencer for a byte-serial DLFloat16 MAC device: alternates A/B operand
// slots on a shared 16-bit bus and reassembles the delayed two-byte result.
//
// state  | meaning
// DEVRST | dev_rst_n held low, down-counter running, no operands issued
// RUN    | device live; phase alternates A-slot (p=0) / B-slot (p=1)
module dlfloat_mac_host #(
  parameter int RES_LAT = 4,
  parameter int CLR_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        clr,
  output logic [15:0] dev_data,
  output logic        dev_rst_n,
  input  logic [7:0]  dev_byte,
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic        busy
);

  localparam int TAG_LEN = RES_LAT + 2;
  localparam int CW      = $clog2(CLR_CYC + 1);

  typedef enum logic {DEVRST = 1'b0, RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 phase_q;
  logic                 b_pend_q;
  logic [15:0]          b_hold_q;
  logic [TAG_LEN-1:0]   tag_q;
  logic [7:0]           lo_q;
  logic                 accept;

  assign op_ready = (state_q == RUN) && phase_q && !clr;
  assign accept   = op_valid && op_ready;
  assign busy     = accept || b_pend_q || (|tag_q) || res_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DEVRST;
      cnt_q   <= CW'(CLR_CYC);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DEVRST: begin
        if (clr)                    cnt_d = CW'(CLR_CYC);
        else if (cnt_q == CW'(1))   state_d = RUN;
        else                        cnt_d = cnt_q - CW'(1);
      end
      RUN: begin
        if (clr) begin
          state_d = DEVRST;
          cnt_d   = CW'(CLR_CYC);
        end
      end
      default: state_d = DEVRST;
    endcase
  end

  // tag_q[i] marks that the B operand of a pending pair went out i cycles ago
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dev_rst_n <= 1'b0;
      phase_q   <= 1'b0;
      dev_data  <= '0;
      b_pend_q  <= 1'b0;
      b_hold_q  <= '0;
      tag_q     <= '0;
      lo_q      <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
    end else begin
      dev_rst_n <= (state_d == RUN);
      phase_q   <= (state_q == RUN && state_d == RUN) ? ~phase_q : 1'b0;
      if (state_d != RUN) begin
        dev_data  <= '0;
        b_pend_q  <= 1'b0;
        tag_q     <= '0;
        res_valid <= 1'b0;
      end else begin
        b_pend_q <= accept;
        if (accept) begin
          dev_data <= op_a;
          b_hold_q <= op_b;
        end else if (b_pend_q) begin
          dev_data <= b_hold_q;
        end else begin
          dev_data <= '0;
        end
        tag_q <= {tag_q[TAG_LEN-2:0], b_pend_q};
        if (tag_q[RES_LAT]) lo_q <= dev_byte;
        res_valid <= tag_q[RES_LAT+1];
        if (tag_q[RES_LAT+1]) res_data <= {dev_byte, lo_q};
      end
    end
  end

endmodule

// File: tb/tb_dlfloat_mac_host.sv
// Bench for dlfloat_mac_host: behavioural MAC device plus a cycle-level reference model
// of the host, checked every cycle, with directed literal checks on top.
module tb_dlfloat_mac_host;
  localparam int RES_LAT = 4;
  localparam int CLR_CYC = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [7:0]  dev_byte = '0;
  logic        op_ready, dev_rst_n, res_valid, busy;
  logic [15:0] dev_data, res_data;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;

  dlfloat_mac_host #(.RES_LAT(RES_LAT), .CLR_CYC(CLR_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .clr(clr), .dev_data(dev_data),
    .dev_rst_n(dev_rst_n), .dev_byte(dev_byte), .res_valid(res_valid),
    .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real dec(input logic [15:0] v);
    real m;
    int  e;
    if (v[14:0] == 15'd0) return 0.0;
    m = 1.0 + real'(v[8:0]) / 512.0;
    e = int'(v[14:9]) - 31;
    while (e > 0) begin m = m * 2.0; e--; end
    while (e < 0) begin m = m / 2.0; e++; end
    return v[15] ? -m : m;
  endfunction

  function automatic logic [15:0] enc(input real x);
    logic       s;
    int         e;
    real        m;
    logic [8:0] f;
    logic [5:0] eb;
    if (x == 0.0) return 16'h0000;
    s = (x < 0.0);
    m = s ? -x : x;
    e = 31;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f  = 9'(int'((m - 1.0) * 512.0));
    eb = 6'(e);
    return {s, eb, f};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  // Device: latches A in its A-slot, accumulates A*B in its B-slot, streams lo then hi.
  logic [7:0]  ring [16];
  initial begin : device
    int          dcyc;
    bit          dp;
    real         dacc;
    logic [15:0] da, dres;
    dcyc = 0; dp = 0; dacc = 0.0; da = '0;
    forever begin
      @(posedge clk);
      if (dev_rst_n !== 1'b1) begin
        dacc = 0.0; dp = 0;
        for (int i = 0; i < 16; i++) ring[i] = 8'hA5;
      end else if (!dp) begin
        da = dev_data; dp = 1;
      end else begin
        dacc = dacc + dec(da) * dec(dev_data);
        dres = enc(dacc);
        ring[(dcyc + RES_LAT) % 16]     = dres[7:0];
        ring[(dcyc + RES_LAT + 1) % 16] = dres[15:8];
        dp = 0;
      end
      dev_byte <= ring[(dcyc + 1) % 16];
      dcyc++;
    end
  end

  // Reference model: expected results are queued at accept time with their due cycle.
  typedef struct { int cyc; logic [15:0] val; } res_t;
  res_t        rq[$];
  int          acc_at[$];
  int          rv_at[$];
  logic [15:0] rv_log[$];

  initial begin : cmp_proc
    bit          m_known, m_run, m_p, er, erv, eb, acc;
    int          m_cnt;
    logic [15:0] m_dd0, m_dd1, m_rd;
    real         m_acc;
    m_known = 0; m_run = 0; m_p = 0; m_cnt = CLR_CYC;
    m_dd0 = '0; m_dd1 = '0; m_rd = '0; m_acc = 0.0;
    forever begin
      @(negedge clk);
      er  = m_run && m_p && !clr;
      acc = op_valid && er;
      if (m_known) begin
        chk("op_ready", op_ready, er);
        chk("dev_rst_n", dev_rst_n, m_run);
        chk("dev_data", dev_data, m_dd0);
        erv = (rq.size() > 0) && (rq[0].cyc == ncyc);
        chk("res_valid", res_valid, erv);
        chk("res_data", res_data, erv ? rq[0].val : m_rd);
        eb = acc || (rq.size() > 0);
        chk("busy", busy, eb);
        if (res_valid === 1'b1) begin rv_log.push_back(res_data); rv_at.push_back(ncyc); end
        if (erv) begin m_rd = rq[0].val; void'(rq.pop_front()); end
      end
      if (!rst_n) begin
        m_known = 1; m_run = 0; m_p = 0; m_cnt = CLR_CYC;
        m_dd0 = '0; m_dd1 = '0; m_rd = '0; m_acc = 0.0; rq.delete();
      end else if (m_known) begin
        if (m_run) begin
          if (clr) begin
            m_run = 0; m_p = 0; m_cnt = CLR_CYC;
            m_dd0 = '0; m_dd1 = '0; m_acc = 0.0; rq.delete();
          end else begin
            m_p = !m_p; m_dd0 = m_dd1; m_dd1 = '0;
            if (acc) begin
              m_dd0 = op_a; m_dd1 = op_b;
              m_acc = m_acc + dec(op_a) * dec(op_b);
              rq.push_back('{ncyc + RES_LAT + 4, enc(m_acc)});
              acc_at.push_back(ncyc);
            end
          end
        end else begin
          m_dd0 = '0;
          if (clr) m_cnt = CLR_CYC;
          else if (m_cnt == 1) begin m_run = 1; m_p = 0; end
          else m_cnt--;
        end
      end
      ncyc++;
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b);
    bit done;
    done = 0;
    @(posedge clk); #1;
    op_valid = 1; op_a = a; op_b = b;
    for (int i = 0; i < 12 && !done; i++) begin
      @(negedge clk);
      if (op_ready) done = 1;
      @(posedge clk); #1;
    end
    op_valid = 0;
    chk("send_accepted", done, 1);
  endtask

  logic [15:0] pa [3] = '{16'h3E00, 16'h4000, 16'h3E00};
  logic [15:0] pb [3] = '{16'h4000, 16'h4000, 16'h3E00};
  logic [15:0] px [3] = '{16'h4000, 16'h4300, 16'h4380};

  initial begin : stim
    int base_a, base_r, idx;
    bit got, found;

    chk("enc_1p0", enc(1.0), 16'h3E00);
    chk("enc_6p0", enc(6.0), 16'h4300);
    chk("enc_7p0", enc(7.0), 16'h4380);
    chk("dec_2p0", dec(16'h4000) == 2.0, 1);

    // reset and device-reset sequence
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("s1_dev_rst_n", dev_rst_n, i >= 4);
      chk("s1_op_ready", op_ready, i == 5);
    end

    // single pair 1.0 * 1.0
    send(16'h3E00, 16'h3E00);
    repeat (12) @(posedge clk); #1;
    chk("s2_rv_count", rv_log.size(), 1);
    if (rv_log.size() >= 1 && acc_at.size() >= 1) begin
      chk("s2_res", rv_log[0], 16'h3E00);
      chk("s2_lat", rv_at[0] - acc_at[0], 8);
    end

    // clear held three cycles (the last two land in DEVRST and reload the counter)
    @(posedge clk); #1 clr = 1;
    repeat (3) @(posedge clk); #1 clr = 0;

    // back-to-back pairs with op_valid held
    base_a = acc_at.size(); base_r = rv_log.size(); idx = 0;
    op_valid = 1; op_a = pa[0]; op_b = pb[0];
    for (int i = 0; i < 30 && idx < 3; i++) begin
      @(negedge clk); got = op_ready;
      @(posedge clk); #1;
      if (got) begin
        idx++;
        if (idx < 3) begin op_a = pa[idx]; op_b = pb[idx]; end
      end
    end
    op_valid = 0;
    chk("s4_accepts", idx, 3);
    repeat (14) @(posedge clk); #1;
    chk("s4_rv_count", rv_log.size() - base_r, 3);
    if (rv_log.size() - base_r == 3 && acc_at.size() - base_a == 3) begin
      for (int i = 0; i < 3; i++) chk("s4_res", rv_log[base_r + i], px[i]);
      for (int i = 0; i < 2; i++) begin
        chk("s4_acc_gap", acc_at[base_a + i + 1] - acc_at[base_a + i], 2);
        chk("s4_rv_gap", rv_at[base_r + i + 1] - rv_at[base_r + i], 2);
      end
    end
    @(negedge clk); chk("s4_busy_idle", busy, 0);

    // clear two cycles after an accept flushes the pair
    base_r = rv_log.size();
    send(16'h4000, 16'h3E00);
    @(posedge clk); #1 clr = 1;
    @(negedge clk); chk("s5_ready_in_clr", op_ready, 0);
    @(posedge clk); #1 clr = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("s5_dev_rst_n_low", dev_rst_n, 0);
    end
    @(negedge clk); chk("s5_dev_rst_n_high", dev_rst_n, 1);
    repeat (12) @(posedge clk); #1;
    chk("s5_no_rv", rv_log.size() - base_r, 0);
    @(negedge clk); chk("s5_busy", busy, 0);

    // op_valid first raised in an A-slot waits for the B-slot
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (op_ready) found = 1;
    end
    chk("s6_sync", found, 1);
    base_r = rv_log.size();
    @(posedge clk); #1;
    op_valid = 1; op_a = 16'h3E00; op_b = 16'h4000;
    @(negedge clk);
    chk("s6_ready_p0", op_ready, 0);
    chk("s6_dd_idle", dev_data, 16'h0000);
    @(negedge clk); chk("s6_ready_p1", op_ready, 1);
    @(posedge clk); #1 op_valid = 0;
    repeat (12) @(posedge clk); #1;
    chk("s6_rv_count", rv_log.size() - base_r, 1);
    if (rv_log.size() - base_r == 1) chk("s6_res", rv_log[base_r], 16'h4000);

    // reset mid-flight discards the pair and reruns the device reset
    base_r = rv_log.size();
    send(16'h4000, 16'h4000);
    @(posedge clk); #1 rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    repeat (14) @(posedge clk); #1;
    chk("s7_no_rv", rv_log.size() - base_r, 0);
    send(16'h3E00, 16'h4000);
    repeat (12) @(posedge clk); #1;
    chk("s7_rv_count", rv_log.size() - base_r, 1);
    if (rv_log.size() - base_r == 1) chk("s7_res", rv_log[base_r], 16'h4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
